// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the 9-bit CPU.
// Optional retired-instruction counter is enabled by defining CTRL_PERF_EN.
module control_sequencer #(
  parameter int unsigned IW       = 9,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  input  logic          mem_ack,
  output logic          fetch_req,
  output logic          pc_inc,
  output logic          mem_sel,
  output logic          alu_en,
  output logic          alu_rs,
  output logic          loadEn,
  output logic          storEn,
  output logic          jump2sub,
  output logic [3:0]    reg_src,
  output logic [3:0]    reg_dst,
  output logic [3:0]    math_op,
  output logic [3:0]    reg_op,
  output logic [3:0]    instr_o,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StHalt} state_e;

  typedef struct packed {
    logic       mem_sel;
    logic       alu_en;
    logic       alu_rs;
    logic       load;
    logic       store;
    logic       j2s;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] math;
    logic [3:0] rop;
    logic [3:0] imm;
  } dec_t;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  dec_t          dec_q, dec_d, dec_w, dec_o;
  logic [7:0]    wait_q, wait_d;
  logic          err_q, err_d;
  logic          dec_halt, unary, ext_bad;

  if (IW > 9) begin : g_ext
    assign ext_bad = |ir_q[IW-1:9];
  end else begin : g_no_ext
    assign ext_bad = 1'b0;
  end

  // Instruction table decode of the held IR.
  always_comb begin
    dec_w     = '0;
    dec_halt  = 1'b0;
    unary     = 1'b0;
    dec_w.imm = ir_q[3:0];
    if (!ir_q[8]) begin
      dec_w.rop = 4'd14;
      dec_w.dst = ir_q[7:4];
      dec_w.src = ir_q[3:0];
    end else begin
      unique case (ir_q[7:4])
        4'h0: begin
          dec_w.load    = 1'b1;
          dec_w.mem_sel = ir_q[3];
          dec_w.dst     = {1'b0, ir_q[2:0]};
        end
        4'h1: begin
          dec_w.store   = 1'b1;
          dec_w.mem_sel = ir_q[3];
          dec_w.src     = {1'b0, ir_q[2:0]};
        end
        4'h2: dec_w.rop = 4'd12;
        4'h3: dec_w.rop = 4'd13;
        4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          dec_w.rop = ir_q[7:4] - 4'd3;
          unary     = 1'b1;
        end
        4'hA, 4'hB: begin
          dec_w.alu_en = 1'b1;
          dec_w.alu_rs = ir_q[4];
          dec_w.math   = ir_q[3:0];
        end
        4'hC: begin
          dec_w.rop = 4'd8;
          unary     = 1'b1;
        end
        4'hD: begin
          dec_w.rop = 4'd9;
          unary     = 1'b1;
        end
        4'hE: begin
          dec_w.rop = ir_q[3] ? 4'd10 : 4'd7;
          dec_w.dst = {1'b0, ir_q[2:0]};
          dec_w.src = {1'b0, ir_q[2:0]};
        end
        default: begin
          case (ir_q[3:0])
            4'h0, 4'h1, 4'h2, 4'h3: dec_w.rop = 4'd11;
            4'hC:                   dec_w.rop = 4'd15;
            4'hD:                   dec_w.j2s = 1'b1;
            default:                dec_halt  = 1'b1;
          endcase
        end
      endcase
    end
    if (unary) begin
      dec_w.dst = ir_q[3:0];
      dec_w.src = ir_q[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    dec_d   = dec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StHalt: if (start) state_d = StFetch;
      StFetch: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        dec_d = dec_w;
        if (ext_bad) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else if (dec_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        wait_d  = '0;
        state_d = (dec_q.load || dec_q.store) ? StMem : StFetch;
      end
      StMem: begin
        if (mem_ack) begin
          state_d = StFetch;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      dec_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Decoded fields are visible only while the instruction is executing or waiting on memory.
  always_comb begin
    dec_o     = (state_q == StExec || state_q == StMem) ? dec_q : '0;
    fetch_req = (state_q == StFetch);
    pc_inc    = (state_q == StExec);
    busy      = (state_q == StFetch) || (state_q == StDecode) ||
                (state_q == StExec) || (state_q == StMem);
    done      = (state_q == StHalt);
    err       = err_q;
    mem_sel   = dec_o.mem_sel;
    alu_en    = dec_o.alu_en;
    alu_rs    = dec_o.alu_rs;
    loadEn    = dec_o.load;
    storEn    = dec_o.store;
    jump2sub  = dec_o.j2s;
    reg_src   = dec_o.src;
    reg_dst   = dec_o.dst;
    math_op   = dec_o.math;
    reg_op    = dec_o.rop;
    instr_o   = dec_o.imm;
  end

`ifdef CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  assign retire = ((state_q == StExec) && !(dec_q.load || dec_q.store)) ||
                  ((state_q == StMem) && mem_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table plus random instruction stream
// checked against a transaction-level reference model.
module tb_control_sequencer;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 16;

  localparam int PH_IDLE   = 0;
  localparam int PH_FETCH  = 1;
  localparam int PH_DECODE = 2;
  localparam int PH_EXEC   = 3;
  localparam int PH_MEM    = 4;
  localparam int PH_HALT   = 5;

  typedef struct packed {
    logic       mem_sel;
    logic       alu_en;
    logic       alu_rs;
    logic       load;
    logic       store;
    logic       j2s;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] math;
    logic [3:0] rop;
    logic [3:0] imm;
    logic       halt;
  } dec_t;

  typedef struct packed {
    logic       fetch_req;
    logic       pc_inc;
    logic       mem_sel;
    logic       alu_en;
    logic       alu_rs;
    logic       load;
    logic       store;
    logic       j2s;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] math;
    logic [3:0] rop;
    logic [3:0] imm;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct {
    string      name;
    logic [8:0] ins;
    int         ack_dly;
    dec_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, instr_valid, mem_ack;
  logic [8:0] instr;
  logic       fetch_req, pc_inc, mem_sel, alu_en, alu_rs, loadEn, storEn, jump2sub;
  logic [3:0] reg_src, reg_dst, math_op, reg_op, instr_o;
  logic       busy, done, err;
`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] retired;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic err_m  = 1'b0;
  int ret_m    = 0;

  always #5 clk = ~clk;

  control_sequencer #(.IW(9), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .instr_valid(instr_valid),
    .mem_ack(mem_ack), .fetch_req(fetch_req), .pc_inc(pc_inc), .mem_sel(mem_sel),
    .alu_en(alu_en), .alu_rs(alu_rs), .loadEn(loadEn), .storEn(storEn),
    .jump2sub(jump2sub), .reg_src(reg_src), .reg_dst(reg_dst), .math_op(math_op),
    .reg_op(reg_op), .instr_o(instr_o), .busy(busy), .done(done), .err(err)
`ifdef CTRL_PERF_EN
    , .retired(retired)
`endif
  );

  // Reference decode written from the opcode map: upper nibble group number plus low nibble.
  function automatic dec_t ref_decode(logic [8:0] ins);
    dec_t       d  = '0;
    int         hi = int'(ins[8:4]);
    logic [3:0] lo = ins[3:0];
    d.imm = lo;
    if (ins < 9'h100) begin
      d.rop = 4'd14; d.dst = ins[7:4]; d.src = lo;
    end else if (hi == 16) begin
      d.load = 1'b1; d.mem_sel = lo[3]; d.dst = {1'b0, lo[2:0]};
    end else if (hi == 17) begin
      d.store = 1'b1; d.mem_sel = lo[3]; d.src = {1'b0, lo[2:0]};
    end else if (hi == 18 || hi == 19) begin
      d.rop = 4'(hi - 6);
    end else if (hi >= 20 && hi <= 25) begin
      d.rop = 4'(hi - 19); d.dst = lo; d.src = lo;
    end else if (hi == 26 || hi == 27) begin
      d.alu_en = 1'b1; d.alu_rs = ins[4]; d.math = lo;
    end else if (hi == 28 || hi == 29) begin
      d.rop = 4'(hi - 20); d.dst = lo; d.src = lo;
    end else if (hi == 30) begin
      d.rop = lo[3] ? 4'd10 : 4'd7; d.dst = {1'b0, lo[2:0]}; d.src = {1'b0, lo[2:0]};
    end else if (lo <= 4'd3) begin
      d.rop = 4'd11;
    end else if (lo == 4'd12) begin
      d.rop = 4'd15;
    end else if (lo == 4'd13) begin
      d.j2s = 1'b1;
    end else begin
      d.halt = 1'b1;
    end
    return d;
  endfunction

  function automatic out_t expect_out(int ph, dec_t d);
    out_t e = '0;
    e.err = err_m;
    case (ph)
      PH_FETCH:  begin e.fetch_req = 1'b1; e.busy = 1'b1; end
      PH_DECODE: e.busy = 1'b1;
      PH_EXEC, PH_MEM: begin
        e.busy = 1'b1; e.pc_inc = (ph == PH_EXEC);
        e.mem_sel = d.mem_sel; e.alu_en = d.alu_en; e.alu_rs = d.alu_rs;
        e.load = d.load; e.store = d.store; e.j2s = d.j2s;
        e.src = d.src; e.dst = d.dst; e.math = d.math; e.rop = d.rop; e.imm = d.imm;
      end
      PH_HALT:   e.done = 1'b1;
      default:   ;
    endcase
    return e;
  endfunction

  function automatic out_t actual_out();
    out_t a;
    a.fetch_req = fetch_req; a.pc_inc = pc_inc; a.mem_sel = mem_sel; a.alu_en = alu_en;
    a.alu_rs = alu_rs; a.load = loadEn; a.store = storEn; a.j2s = jump2sub;
    a.src = reg_src; a.dst = reg_dst; a.math = math_op; a.rop = reg_op; a.imm = instr_o;
    a.busy = busy; a.done = done; a.err = err;
    return a;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a = actual_out();
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h", nm, a, e);
    end
`ifdef CTRL_PERF_EN
    n_checks++;
    if (retired !== CNT_W'(ret_m)) begin
      n_err++;
      $display("FAIL %s retired: got %0d expected %0d", nm, retired, CNT_W'(ret_m));
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in a FETCH cycle; leaves in the next FETCH cycle or in HALT.
  task automatic run_instr(input string nm, input logic [8:0] ins, input dec_t d,
                           input int vdly, input int ack_dly, output logic halted);
    halted = 1'b0;
    for (int i = 0; i < vdly; i++) begin
      instr_valid = 1'b0; instr = 9'($urandom);
      check({nm, ":wait"}, expect_out(PH_FETCH, '0));
      step();
    end
    instr = ins; instr_valid = 1'b1;
    check({nm, ":fetch"}, expect_out(PH_FETCH, '0));
    step();
    instr = 9'($urandom); instr_valid = 1'($urandom_range(0, 1));
    check({nm, ":decode"}, expect_out(PH_DECODE, '0));
    step();
    if (d.halt) begin
      check({nm, ":halt"}, expect_out(PH_HALT, '0));
      halted = 1'b1;
      return;
    end
    instr_valid = 1'($urandom_range(0, 1));
    check({nm, ":exec"}, expect_out(PH_EXEC, d));
    step();
    if (!(d.load || d.store)) begin
      ret_m++;
      return;
    end
    for (int i = 0; i < MAX_WAIT; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      mem_ack = (i == ack_dly);
      check({nm, ":mem"}, expect_out(PH_MEM, d));
      step();
      mem_ack = 1'b0;
      if (i == ack_dly) begin
        ret_m++;
        return;
      end
    end
    err_m = 1'b1;
    check({nm, ":timeout"}, expect_out(PH_HALT, '0));
    halted = 1'b1;
  endtask

  task automatic restart(input string nm);
    instr_valid = 1'b0;
    check({nm, ":done"}, expect_out(PH_HALT, '0));
    start = 1'b1;
    step();
    start = 1'b0;
    check({nm, ":resume"}, expect_out(PH_FETCH, '0));
  endtask

  vec_t vecs[9];
  logic halted;
  dec_t d;

  initial begin
    vecs[0] = '{"mov",     9'h035, 0,   '{rop: 4'd14, dst: 4'd3, src: 4'd5, imm: 4'h5, default: '0}};
    vecs[1] = '{"load",    9'h10A, 1,   '{load: 1'b1, mem_sel: 1'b1, dst: 4'd2, imm: 4'hA, default: '0}};
    vecs[2] = '{"alu",     9'h1B6, 0,   '{alu_en: 1'b1, alu_rs: 1'b1, math: 4'd6, imm: 4'h6, default: '0}};
    vecs[3] = '{"lsrc",    9'h1D0, 0,   '{rop: 4'd9, default: '0}};
    vecs[4] = '{"lslc",    9'h1C3, 0,   '{rop: 4'd8, dst: 4'd3, src: 4'd3, imm: 4'h3, default: '0}};
    vecs[5] = '{"val_lo",  9'h125, 0,   '{rop: 4'd12, imm: 4'h5, default: '0}};
    vecs[6] = '{"j2s",     9'h1FD, 0,   '{j2s: 1'b1, imm: 4'hD, default: '0}};
    vecs[7] = '{"halt",    9'h1F4, 0,   '{halt: 1'b1, default: '0}};
    vecs[8] = '{"st_tmo",  9'h11A, 100, '{store: 1'b1, mem_sel: 1'b1, src: 4'd2, imm: 4'hA, default: '0}};

    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0; instr = '0;
    step(); step();
    reset = 1'b0;
    check("reset", expect_out(PH_IDLE, '0));
    step();
    check("idle_hold", expect_out(PH_IDLE, '0));
    start = 1'b1;
    step();
    start = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_instr(vecs[v].name, vecs[v].ins, vecs[v].exp, 0, vecs[v].ack_dly, halted);
      if (halted) restart(vecs[v].name);
    end

    // Reset while a load waits in MEM: everything clears on the next cycle.
    instr = 9'h10A; instr_valid = 1'b1;
    check("rstmem:fetch", expect_out(PH_FETCH, '0));
    step();
    instr_valid = 1'b0;
    step();
    check("rstmem:exec", expect_out(PH_EXEC, ref_decode(9'h10A)));
    step();
    check("rstmem:mem", expect_out(PH_MEM, ref_decode(9'h10A)));
    reset = 1'b1;
    step();
    reset = 1'b0; err_m = 1'b0; ret_m = 0;
    check("rstmem:cleared", expect_out(PH_IDLE, '0));
    step();
    check("rstmem:idle", expect_out(PH_IDLE, '0));
    start = 1'b1;
    step();
    start = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [8:0] ins;
      ins = 9'($urandom);
      d = ref_decode(ins);
      run_instr("rand", ins, d, $urandom_range(0, 2), $urandom_range(0, MAX_WAIT), halted);
      if (halted) restart("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit for the 9-bit CPU that replaces the purely combinational decode path with a registered fetch/decode/execute/memory sequencer. It owns the instruction register and decodes with the instr_pack ISA table. lsrc gets its own code, distinct from lslc. It drives single-cycle execute strobes to the ALU and register file, and holds load/store requests until memory acknowledges them. It sits between the instruction ROM/PC and the datapath, and reports halt, timeout and retired-instruction status to the top level.

Parameters:
IW, 9, instruction width. Bits [8:0] are decoded. Any nonzero bit in [IW-1:9] makes the instruction illegal.
MAX_WAIT, 8, maximum MEM-state cycles without mem_ack before timeout (range 1..255).
CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  leaves IDLE/HALT when sampled high
instr  in  IW  instruction word from instruction memory
instr_valid  in  1  instr is valid this cycle
mem_ack  in  1  data memory has completed the load/store
fetch_req  out  1  request for the next instruction
pc_inc  out  1  one-cycle PC advance pulse
mem_sel  out  1  data-memory bank select (instr[3])
alu_en  out  1  ALU operation strobe
alu_rs  out  1  ALU result select (instr[4])
loadEn  out  1  load request
storEn  out  1  store request
jump2sub  out  1  jump-to-subroutine strobe
reg_src  out  4  source register
reg_dst  out  4  destination register
math_op  out  4  ALU opcode (instr[3:0])
reg_op  out  4  0 none, 1 incr, 2 decr, 3 jizr, 4 jnzr, 5 bizr, 6 bnzr, 7 seth, 8 lslc, 9 lsrc, 10 flip, 11 func, 12 val_lo, 13 val_hi, 14 mov, 15 ljp
instr_o  out  4  immediate / ljp index (instr[3:0])
busy  out  1  high in FETCH, DECODE, EXEC, MEM
done  out  1  high in HALT
err  out  1  sticky: timeout or illegal instruction

Behaviour:
- Reset:
  - state goes to IDLE.
  - All outputs go to 0, including the IR, wait counter, err and the optional counter.
  - Reset asserted mid-operation aborts immediately; no strobe fires in the following cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: outputs 0. If start=1, go to FETCH next cycle.
- FETCH:
  - fetch_req=1 while waiting.
  - On instr_valid=1, IR <= instr and go to DECODE.
  - instr_valid with fetch_req=0 is ignored.
- DECODE: one cycle. Decode the IR into registered fields.
  - Halt encoding: [8:7]=3, [6:5]=3, [4]=1, [3:0] not in {0..3, 12, 13}. It goes to HALT and is not counted as retired.
  - Illegal: extension bits nonzero. Sets err and goes to HALT.
  - Otherwise go to EXEC.
- EXEC: exactly one cycle.
  - Present decoded reg_src, reg_dst, math_op, reg_op, instr_o, alu_en, alu_rs, jump2sub, mem_sel, and pulse pc_inc.
  - Load/store: assert loadEn or storEn and go to MEM. All others go to FETCH.
- MEM:
  - Hold loadEn/storEn, mem_sel and reg field constant.
  - mem_ack=1 (including on the first MEM cycle): drop the request, go to FETCH.
  - Wait counter increments per MEM cycle without ack. At count == MAX_WAIT: set err, go to HALT.
- HALT: done=1.
  - start=1 clears done and goes to FETCH.
  - err stays set until reset.
- Outside EXEC/MEM, all strobes and fields (reg_*, math_op, reg_op, instr_o, mem_sel, alu_rs) are 0. Nothing is ever driven to z.
- Per instruction, the minimum is 3 cycles from fetch_req high to the next fetch_req, with instr_valid arriving in the same cycle as the request. Load/store adds at least 1 cycle.

Optional Feature:
CTRL_PERF_EN
- Defined: adds output retired [CNT_W-1:0].
  - Increments on each EXEC→FETCH transition and each MEM exit on mem_ack.
  - Wraps from all-ones to 0.
  - Cleared only by reset.
- Undefined: no port, no counter logic.

Test Plan:
- reset, start=1, instr=0x035 valid on first request → EXEC cycle shows reg_op=14, reg_dst=3, reg_src=5, pc_inc=1; fetch_req returns 3 cycles after the first request.
- instr=0x10A, mem_ack after 2 MEM cycles → loadEn=1, mem_sel=1, reg_dst=2 for EXEC+2 cycles; then FETCH; err=0.
- instr=0x1B6 → single EXEC cycle with alu_en=1, alu_rs=1, math_op=6; instr=0x1D0 → reg_op=9 (not 8).
- instr=0x11A (store r2, mem_sel=1), mem_ack never arrives, MAX_WAIT=8 → storEn high in EXEC + 8 MEM cycles; then err=1, done=1.
- instr=0x1F4 → HALT, done=1, no pc_inc; start=1 → done=0, fetch_req=1 the next cycle.
- reset pulsed during MEM → all outputs 0 next cycle, state IDLE; with CTRL_PERF_EN, retired=0.
